// File: rtl/return_addr_stack_pkg.sv
// Shared constants and operation decode for the PC / return-address-stack path.
package return_addr_stack_pkg;

  localparam int              PC_W      = 16;
  localparam int              RAS_DEPTH = 8;
  localparam logic [PC_W-1:0] RESET_PC  = 16'h0000;

  // One operation per cycle; SWAP is a call and a return issued together.
  typedef enum logic [1:0] {
    RAS_IDLE = 2'b00,
    RAS_POP  = 2'b01,
    RAS_PUSH = 2'b10,
    RAS_SWAP = 2'b11
  } ras_op_e;

  function automatic ras_op_e ras_decode(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return RAS_PUSH;
      2'b01:   return RAS_POP;
      2'b11:   return RAS_SWAP;
      default: return RAS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/return_addr_stack_err_flags.sv
// Sticky overflow/underflow flags; a new error in the same cycle beats clr_err.
module return_addr_stack_err_flags (
  input  logic clk,
  input  logic rst,
  input  logic set_ovf_i,
  input  logic set_udf_i,
  input  logic clr_err_i,
  output logic overflow_o,
  output logic underflow_o
);

  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = set_ovf_i | (ovf_q & ~clr_err_i);
    udf_d = set_udf_i | (udf_q & ~clr_err_i);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: rtl/return_addr_stack.sv
// Return address stack: DEPTH x AW LIFO with zero-latency top read and registered pop result.
// Define RAS_WRAP_EN to make a push into a full stack overwrite the oldest entry.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int AW    = PC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [AW-1:0]          push_addr,
  input  logic                   pop,
  input  logic                   clr_err,
  output logic [AW-1:0]          top_addr,
  output logic                   pop_valid,
  output logic [AW-1:0]          pop_addr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] SP_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [AW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d, sp_top;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_valid_q, pop_valid_d;
  logic [AW-1:0]    pop_addr_q, pop_addr_d;

  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic             set_ovf, set_udf;
  ras_op_e          op;

  assign op     = ras_decode(push, pop);
  assign sp_top = sp_q - SP_ONE;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_MAX);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    sp_d        = sp_q;
    count_d     = count_q;
    pop_valid_d = 1'b0;
    pop_addr_d  = pop_addr_q;
    mem_we      = 1'b0;
    mem_waddr   = sp_q;
    set_ovf     = 1'b0;
    set_udf     = 1'b0;

    case (op)
      RAS_PUSH: begin
        if (!full) begin
          mem_we  = 1'b1;
          sp_d    = sp_q + SP_ONE;
          count_d = count_q + CNT_ONE;
        end else begin
          set_ovf = 1'b1;
`ifdef RAS_WRAP_EN
          // With a full stack, sp already points at the oldest entry.
          mem_we  = 1'b1;
          sp_d    = sp_q + SP_ONE;
`endif
        end
      end
      RAS_POP: begin
        if (empty) begin
          set_udf = 1'b1;
        end else begin
          sp_d        = sp_top;
          count_d     = count_q - CNT_ONE;
          pop_valid_d = 1'b1;
          pop_addr_d  = top_addr;
        end
      end
      RAS_SWAP: begin
        if (empty) begin
          mem_we  = 1'b1;
          sp_d    = sp_q + SP_ONE;
          count_d = CNT_ONE;
          set_udf = 1'b1;
        end else begin
          // Return and call together: replace the top in place, depth unchanged.
          mem_we      = 1'b1;
          mem_waddr   = sp_top;
          pop_valid_d = 1'b1;
          pop_addr_d  = top_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q        <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      pop_addr_q  <= AW'(RESET_PC);
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      pop_addr_q  <= pop_addr_d;
    end
  end

  // NOTE: the array has no reset; entries are only read below count, which reset clears.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= push_addr;
    end
  end

  assign top_addr  = mem_q[sp_top];
  assign pop_valid = pop_valid_q;
  assign pop_addr  = pop_addr_q;
  assign count     = count_q;

  return_addr_stack_err_flags u_err_flags (
    .clk         (clk),
    .rst         (rst),
    .set_ovf_i   (set_ovf),
    .set_udf_i   (set_udf),
    .clr_err_i   (clr_err),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: directed cases plus random traffic vs a queue model.
module tb_return_addr_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   push = 1'b0;
  logic [AW-1:0]          push_addr = '0;
  logic                   pop = 1'b0;
  logic                   clr_err = 1'b0;
  logic [AW-1:0]          top_addr;
  logic                   pop_valid;
  logic [AW-1:0]          pop_addr;
  logic [$clog2(DEPTH):0] count;
  logic                   empty, full, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the back of the queue is the top of stack.
  logic [AW-1:0] mq[$];
  bit            m_ovf, m_udf, m_pv;
  logic [AW-1:0] m_pa;

  return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
    .clr_err   (clr_err),
    .top_addr  (top_addr),
    .pop_valid (pop_valid),
    .pop_addr  (pop_addr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
    m_pv  = 0;
    m_pa  = '0;
  endtask

  task automatic model_update(input bit p, input logic [AW-1:0] a, input bit po, input bit c);
    bit set_o = 0;
    bit set_u = 0;
    m_pv = 0;
    if (p && po) begin
      if (mq.size() == 0) begin
        mq.push_back(a);
        set_u = 1;
      end else begin
        m_pv = 1;
        m_pa = mq[mq.size()-1];
        mq[mq.size()-1] = a;
      end
    end else if (p) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(a);
      end else begin
        set_o = 1;
`ifdef RAS_WRAP_EN
        void'(mq.pop_front());
        mq.push_back(a);
`endif
      end
    end else if (po) begin
      if (mq.size() == 0) set_u = 1;
      else begin
        m_pv = 1;
        m_pa = mq.pop_back();
      end
    end
    m_ovf = set_o | (m_ovf & !c);
    m_udf = set_u | (m_udf & !c);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},     32'(count),     32'(mq.size()));
    check({tag, ".empty"},     32'(empty),     32'(mq.size() == 0));
    check({tag, ".full"},      32'(full),      32'(mq.size() == DEPTH));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    check({tag, ".pop_valid"}, 32'(pop_valid), 32'(m_pv));
    if (m_pv)           check({tag, ".pop_addr"}, 32'(pop_addr), 32'(m_pa));
    if (mq.size() != 0) check({tag, ".top_addr"}, 32'(top_addr), 32'(mq[mq.size()-1]));
  endtask

  // Inputs change on the falling edge; results are compared 1 time unit after the rising edge.
  task automatic step(input string tag, input bit p, input logic [AW-1:0] a, input bit po,
                      input bit c);
    @(negedge clk);
    push = p; push_addr = a; pop = po; clr_err = c;
    @(posedge clk);
    #1;
    model_update(p, a, po, c);
    push = 0; pop = 0; clr_err = 0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    push = 0; pop = 0; clr_err = 0;
    rst = 1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    check("por.pop_addr", 32'(pop_addr), 32'h0);
    @(negedge clk);
    rst = 0;

    // Reset asserted during a push discards it.
    step("pre", 1, 16'h0055, 0, 0);
    @(negedge clk);
    push = 1; push_addr = 16'h1234; rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    check_all("rst_mid_push");
    @(negedge clk);
    rst = 0; push = 0;
    step("post_rst_push", 1, 16'h0077, 0, 0);
    check("post_rst_top", 32'(top_addr), 32'h0077);

    // LIFO order.
    do_reset("rst_lifo");
    step("lifo_p0", 1, 16'h0010, 0, 0);
    step("lifo_p1", 1, 16'h0020, 0, 0);
    step("lifo_p2", 1, 16'h0030, 0, 0);
    step("lifo_q0", 0, '0, 1, 0);
    check("lifo_q0_addr", 32'(pop_addr), 32'h0030);
    step("lifo_q1", 0, '0, 1, 0);
    check("lifo_q1_addr", 32'(pop_addr), 32'h0020);
    step("lifo_q2", 0, '0, 1, 0);
    check("lifo_q2_addr", 32'(pop_addr), 32'h0010);
    check("lifo_empty", 32'(empty), 32'h1);
    step("lifo_idle", 0, '0, 0, 0);

    // Underflow, then clear; clear together with a new error keeps the flag.
    step("udf_pop", 0, '0, 1, 0);
    check("udf_flag", 32'(underflow), 32'h1);
    step("udf_clr", 0, '0, 0, 1);
    check("udf_cleared", 32'(underflow), 32'h0);
    step("udf_clr_vs_err", 0, '0, 1, 1);
    check("udf_err_wins", 32'(underflow), 32'h1);

    // Fill past capacity, then drain.
    do_reset("rst_full");
    for (int i = 0; i < 9; i++) step("full_push", 1, 16'h0100 + 16'(i), 0, 0);
    check("full_flag", 32'(full), 32'h1);
    check("full_ovf", 32'(overflow), 32'h1);
`ifdef RAS_WRAP_EN
    check("full_top", 32'(top_addr), 32'h0108);
`else
    check("full_top", 32'(top_addr), 32'h0107);
`endif
    for (int i = 0; i < 8; i++) step("full_drain", 0, '0, 1, 0);
`ifdef RAS_WRAP_EN
    check("full_oldest", 32'(pop_addr), 32'h0101);
`else
    check("full_oldest", 32'(pop_addr), 32'h0100);
`endif
    check("full_drained", 32'(empty), 32'h1);

    // Push and pop together when full.
    for (int i = 0; i < 8; i++) step("fs_fill", 1, 16'h0200 + 16'(i), 0, 0);
    step("fs_swap", 1, 16'h0ABC, 1, 0);
    check("fs_swap_pa", 32'(pop_addr), 32'h0207);
    check("fs_swap_top", 32'(top_addr), 32'h0ABC);

    // Simultaneous push/pop on non-empty and empty stacks.
    do_reset("rst_sim");
    step("sim_p", 1, 16'h00AA, 0, 0);
    step("sim_swap", 1, 16'h00BB, 1, 0);
    check("sim_pa", 32'(pop_addr), 32'h00AA);
    check("sim_top", 32'(top_addr), 32'h00BB);
    check("sim_cnt", 32'(count), 32'h1);
    step("sim_pop", 0, '0, 1, 0);
    step("sim_swap_empty", 1, 16'h00CC, 1, 0);
    check("sim_e_cnt", 32'(count), 32'h1);
    check("sim_e_udf", 32'(underflow), 32'h1);
    check("sim_e_pv", 32'(pop_valid), 32'h0);

    // Random traffic with a drifting push/pop bias so both boundaries get exercised.
    do_reset("rst_rand");
    for (int blk = 0; blk < 20; blk++) begin
      int bias = $urandom_range(15, 85);
      for (int cyc = 0; cyc < 100; cyc++) begin
        bit p  = ($urandom_range(0, 99) < bias);
        bit po = ($urandom_range(0, 99) >= bias);
        bit c  = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 7) == 0) begin
          p  = 1;
          po = 1;
        end
        if ($urandom_range(0, 499) == 0) do_reset("rand_rst");
        else step("rand", p, AW'($urandom_range(0, 16'hFFFF)), po, c);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 Parameters SHALL be: DEPTH, default 8, number of entries (power of two, 2..64); AW, default 16, address width (matches 16-bit PC).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 push  input  1  call strobe; store push_addr this cycle.
REQ-005 push_addr  input  AW  return address (incremented PC from fetch stage).
REQ-006 pop  input  1  return strobe; remove top entry this cycle.
REQ-007 top_addr  output  AW  current top-of-stack address; valid when empty=0.
REQ-008 pop_valid  output  1  registered; high one cycle after an accepted pop.
REQ-009 pop_addr  output  AW  registered address removed by the accepted pop; qualified by pop_valid.
REQ-010 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-011 empty / full  output  1 each  count==0 / count==DEPTH, combinational from registered count.
REQ-012 overflow / underflow  output  1 each  sticky error flags, cleared only by rst or clr_err.
REQ-013 clr_err  input  1  synchronous clear of overflow and underflow.

Function
REQ-014 Storage SHALL be a DEPTH x AW register array with a registered stack pointer; top_addr SHALL read the entry at sp-1 combinationally (0 latency).
REQ-015 Push only, not full: write push_addr at sp, sp+1, count+1; new top visible the next cycle.
REQ-016 Pop only, not empty: sp-1, count-1; pop_valid=1 and pop_addr=old top on the next cycle.
REQ-017 Pop when empty: no state change, pop_valid stays 0, underflow set next cycle.
REQ-018 Push and pop in same cycle, not empty: old top goes to pop_addr with pop_valid=1, top entry overwritten with push_addr, count unchanged.
REQ-019 Push and pop in same cycle, empty: push executes (count becomes 1), underflow set, pop_valid stays 0.
REQ-020 Push when full: behaviour per REQ-026/REQ-027.
REQ-021 clr_err in the same cycle as a new error: the error wins (flag set).
REQ-022 pop_valid SHALL be low in every cycle not following an accepted pop.
REQ-023 The pointer SHALL wrap modulo DEPTH; count saturates at DEPTH and 0.

Reset
REQ-024 rst SHALL immediately force sp=0, count=0, empty=1, full=0, pop_valid=0, pop_addr=0, overflow=0, underflow=0; array contents need not be cleared; top_addr is don't-care while empty.
REQ-025 rst asserted mid-operation SHALL discard any push/pop in that cycle; first operation is accepted on the first clk edge after rst deasserts.

Configuration
REQ-026 With RAS_WRAP_EN defined: push when full overwrites the oldest entry (circular), sp advances, count stays DEPTH, overflow set.
REQ-027 Without RAS_WRAP_EN: push when full is dropped, contents unchanged, overflow set; push+pop when full behaves per REQ-018 in both builds.

Structure
REQ-028 Shared package SHALL hold the PC width constant (16), default RAS depth, and the reset PC value used by the PC/return-stack path.
REQ-029 No sub-module is required; the error-flag logic MAY be a sub-module ras_err_flags if reused.

Verification
REQ-030 Reset: assert rst mid-push of 0x1234 -> count=0, empty=1, pop_valid=0, flags 0.
REQ-031 LIFO: push 0x0010, 0x0020, 0x0030, then 3 pops -> pop_addr 0x0030, 0x0020, 0x0010 each with pop_valid one cycle after pop; empty=1 at end.
REQ-032 Underflow: pop on empty -> pop_valid=0, underflow=1; clr_err -> underflow=0.
REQ-033 Full: push 0x0100..0x0108 (9 pushes, DEPTH 8) -> full=1, overflow=1; top_addr=0x0107 without RAS_WRAP_EN, 0x0108 with it; 8 pops drain to oldest 0x0100 resp. 0x0101.
REQ-034 Simultaneous: with top 0x00AA, push 0x00BB and pop together -> pop_addr=0x00AA, top_addr=0x00BB, count unchanged; on empty -> count=1, underflow=1.
REQ-035 Random push/pop sequence SHALL be checked against a reference LIFO model for top_addr, count and flags every cycle.
